// File: rtl/conv_encoder_if.sv
// Handshake bundle for conv_encoder: bit input side,
// code-symbol output side and frame status.
interface conv_encoder_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sym;
  logic       sym_valid;
  logic       sym_ready;
  logic       sym_last;
  logic       busy;

  modport master (
    output in_bit, in_valid, sym_ready,
    input  in_ready, sym, sym_valid, sym_last, busy
  );

  modport slave (
    input  in_bit, in_valid, sym_ready,
    output in_ready, sym, sym_valid, sym_last, busy
  );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with framed output.
// CONV_ENC_TAIL_EN appends two zero tail bits per frame.
module conv_encoder #(
  parameter int         FRAME_LEN = 8,
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101
) (
  input logic           clk,
  input logic           rst,
  conv_encoder_if.slave bus
);

  localparam int CW = (FRAME_LEN > 1) ?
                      $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(FRAME_LEN - 1);

  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [1:0]    sym_q, sym_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic          adv;
  logic          in_rdy;

`ifdef CONV_ENC_TAIL_EN
  typedef enum logic {DATA, TAIL} state_e;
  state_e state_q, state_d;
  logic   tail_cnt_q, tail_cnt_d;
`endif

  function automatic logic [1:0] encode(
    input logic u,
    input logic a,
    input logic b
  );
    return {^({u, a, b} & G0), ^({u, a, b} & G1)};
  endfunction

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    sym_d     = sym_q;
    last_d    = last_q;
    vld_d     = vld_q;
    adv       = !vld_q || bus.sym_ready;
    in_rdy    = 1'b0;
`ifdef CONV_ENC_TAIL_EN
    state_d    = state_q;
    tail_cnt_d = tail_cnt_q;
`endif
    if (vld_q && bus.sym_ready)
      vld_d = 1'b0;
`ifdef CONV_ENC_TAIL_EN
    unique case (1'b1)
      state_q == DATA: begin
        in_rdy = adv && !rst;
        if (in_rdy && bus.in_valid) begin
          sym_d  = encode(bus.in_bit, s1_q, s2_q);
          vld_d  = 1'b1;
          last_d = 1'b0;
          s1_d   = bus.in_bit;
          s2_d   = s1_q;
          if (bit_cnt_q == CNT_LAST) begin
            bit_cnt_d = '0;
            state_d   = TAIL;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      state_q == TAIL: begin
        if (adv) begin
          sym_d      = encode(1'b0, s1_q, s2_q);
          vld_d      = 1'b1;
          last_d     = tail_cnt_q;
          s1_d       = 1'b0;
          s2_d       = s1_q;
          tail_cnt_d = !tail_cnt_q;
          if (tail_cnt_q)
            state_d = DATA;
        end
      end
      default: ;
    endcase
`else
    in_rdy = adv && !rst;
    if (in_rdy && bus.in_valid) begin
      sym_d  = encode(bus.in_bit, s1_q, s2_q);
      vld_d  = 1'b1;
      last_d = 1'b0;
      s1_d   = bus.in_bit;
      s2_d   = s1_q;
      if (bit_cnt_q == CNT_LAST) begin
        // next frame must start in trellis state 0
        bit_cnt_d = '0;
        last_d    = 1'b1;
        s1_d      = 1'b0;
        s2_d      = 1'b0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      sym_q     <= 2'b00;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      state_q    <= DATA;
      tail_cnt_q <= 1'b0;
`endif
    end else begin
      bit_cnt_q <= bit_cnt_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      sym_q     <= sym_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
`ifdef CONV_ENC_TAIL_EN
      state_q    <= state_d;
      tail_cnt_q <= tail_cnt_d;
`endif
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.sym       = sym_q;
  assign bus.sym_valid = vld_q;
  assign bus.sym_last  = last_q;
`ifdef CONV_ENC_TAIL_EN
  assign bus.busy = (bit_cnt_q != '0) ||
                    (state_q == TAIL);
`else
  assign bus.busy = (bit_cnt_q != '0);
`endif

endmodule
